// File: rtl/instruction_store.sv
// instruction_store: on-chip instruction memory. After reset it zeroes itself one word per cycle
// (CLEAR), then serves single-cycle-latency fetches (READY). It can also be loaded at runtime
// (PROGRAM).
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   fetch_req    read request for the word at pc (served only in READY)
//   pc           fetch address
//   instruction  registered fetched word, held between fetches
//   instr_valid  one-cycle pulse when instruction has been updated
//   fetch_fault  one-cycle pulse on an out-of-range fetch or program write
//   prog_en      request / hold program mode
//   prog_we      program write strobe (PROGRAM only)
//   prog_addr    program write address
//   prog_data    program write data
//   busy         registered, high while in CLEAR or PROGRAM
//
// Addresses at or above DEPTH are out of range; 2**ADDR_WIDTH must be >= DEPTH.
module instruction_store #(
    parameter int unsigned INSTR_WIDTH = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_req,
    input  logic [ADDR_WIDTH-1:0]  pc,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic                   fetch_fault,
    input  logic                   prog_en,
    input  logic                   prog_we,
    input  logic [ADDR_WIDTH-1:0]  prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic                   busy
);

    // One extra bit so the range limit itself fits (DEPTH may equal 2**ADDR_WIDTH).
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_L  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_READY   = 2'd1,
        ST_PROGRAM = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  clr_cnt_q, clr_cnt_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   fault_q, fault_d;
    logic                   busy_q, busy_d;

    logic                   mem_we_c;
    logic [ADDR_WIDTH-1:0]  mem_waddr_c;
    logic [INSTR_WIDTH-1:0] mem_wdata_c;

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    logic pc_ok_c;
    logic waddr_ok_c;

    assign pc_ok_c    = ({1'b0, pc} < DEPTH_L);
    assign waddr_ok_c = ({1'b0, prog_addr} < DEPTH_L);

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state, memory write port and output logic.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        instr_d     = instr_q;
        valid_d     = 1'b0;
        fault_d     = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = clr_cnt_q;
        mem_wdata_c = '0;

        case (state_q)
            ST_CLEAR: begin
                // Sweep addresses 0..DEPTH-1 writing zero; all requests ignored.
                mem_we_c = 1'b1;
                if (clr_cnt_q == LAST_L) begin
                    clr_cnt_d = '0;
                    state_d   = ST_READY;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                if (fetch_req) begin
                    if (pc_ok_c) begin
                        instr_d = mem_q[pc];
                        valid_d = 1'b1;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
                if (prog_en) begin
                    state_d = ST_PROGRAM;
                end
            end
            ST_PROGRAM: begin
                // The write in the exit cycle still lands, so the first fetch
                // back in READY sees it.
                if (prog_we) begin
                    if (waddr_ok_c) begin
                        mem_we_c    = 1'b1;
                        mem_waddr_c = prog_addr;
                        mem_wdata_c = prog_data;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
                if (!prog_en) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        busy_d = (state_d != ST_READY);
    end

    // Storage array; contents are only defined after a CLEAR sweep completes.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign fetch_fault = fault_q;
    assign busy        = busy_q;

endmodule

// File: doc/instruction_store.md
INSTRUCTION_STORE -- requirements
Module: instruction_store

Interface
REQ-001 Parameter INSTR_WIDTH, default 8, sets the instruction word width in bits.
REQ-002 Parameter DEPTH, default 256, sets the number of instruction words stored.
REQ-003 Parameter ADDR_WIDTH, default 8, sets the width of pc and prog_addr; the block SHALL require 2^ADDR_WIDTH >= DEPTH.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 fetch_req  input  1  requests a read of the word at pc.
REQ-007 pc  input  ADDR_WIDTH  fetch address.
REQ-008 instruction  output  INSTR_WIDTH  registered fetched word.
REQ-009 instr_valid  output  1  one-cycle pulse: instruction is updated this cycle.
REQ-010 fetch_fault  output  1  one-cycle pulse: the last fetch or program write was out of range.
REQ-011 prog_en  input  1  requests program mode (runtime loading).
REQ-012 prog_we  input  1  write strobe, honoured only in PROGRAM.
REQ-013 prog_addr  input  ADDR_WIDTH  write address.
REQ-014 prog_data  input  INSTR_WIDTH  write data.
REQ-015 busy  output  1  high while in CLEAR or PROGRAM.

Function
REQ-016 The block SHALL implement three states, CLEAR, READY and PROGRAM, with a DEPTH-counting clear counter.
REQ-017 CLEAR: one word per cycle, addresses 0..DEPTH-1, written to zero; after exactly DEPTH cycles, go to READY; fetch_req, prog_en and prog_we are ignored.
REQ-018 READY, fetch_req=1, pc<DEPTH: on the next edge, instruction<=memory[pc] and instr_valid=1 for one cycle (read latency 1).
REQ-019 READY, fetch_req=1, pc>=DEPTH: instruction holds, instr_valid=0, fetch_fault=1 for one cycle.
REQ-020 fetch_req=0 (any state): instruction holds its value and instr_valid=0.
REQ-021 READY, prog_en=1: go to PROGRAM on the next edge; a fetch_req in that same cycle is still served per REQ-018/019.
REQ-022 PROGRAM, prog_we=1, prog_addr<DEPTH: memory[prog_addr]<=prog_data on the edge.
REQ-023 PROGRAM, prog_we=1, prog_addr>=DEPTH: the write is dropped and fetch_fault=1 for one cycle.
REQ-024 PROGRAM: fetch_req is ignored, with instr_valid=0 and instruction held.
REQ-025 PROGRAM, prog_en=0: go to READY on the next edge; a prog_we in that same cycle is still performed.
REQ-026 A word written in PROGRAM SHALL be returned by the first fetch after return to READY (no stale data).
REQ-027 Back-to-back fetches every cycle in READY SHALL each yield one instr_valid pulse with the correct data; there are no bubbles.
REQ-028 busy SHALL be registered, and high exactly when the state is CLEAR or PROGRAM.

Reset
REQ-029 rst_n=0 SHALL immediately force: state CLEAR, clear counter 0, instruction 0, instr_valid 0, fetch_fault 0, busy 1.
REQ-030 Reset asserted mid-CLEAR or mid-PROGRAM SHALL abort that operation; after release, CLEAR restarts from address 0.
REQ-031 Memory contents are not reset directly; they are zero only after CLEAR completes.

Verification
REQ-032 Defaults. Release reset, fetch_req=0 -> busy=1 for exactly 256 cycles, then 0; a fetch of pc=0x10 returns 0x00 with instr_valid.
REQ-033 Program then fetch. Program mode: write 0xA5@0x03 and 0x3C@0xFF; exit; fetch pc=0x03, then 0xFF on consecutive cycles -> 0xA5, then 0x3C, on consecutive cycles, each with instr_valid=1.
REQ-034 Out of range. DEPTH=200, ADDR_WIDTH=8: fetch pc=200 -> fetch_fault pulse, instr_valid=0, instruction unchanged; program write to 250 -> fetch_fault pulse, no memory change.
REQ-035 Simultaneous events. fetch_req and prog_en in the same READY cycle -> fetch served next cycle and state PROGRAM; fetch_req during PROGRAM -> no instr_valid.
REQ-036 Reset mid-operation. Assert rst_n=0 at clear count 100 -> outputs reset immediately; after release, busy stays high a full 256 cycles. Reset during PROGRAM -> CLEAR, and previously written words read 0x00 afterwards.
